// File: rtl/pipeline_exec_ctrl.sv
// Execution sequencer for the 5-stage pipeline: turns debug RUN/STEP/STOP commands
// into the global advance enable, folds in load-use stalls, and drains on HALT.
module pipeline_exec_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_halt_in_ID,
  input  logic             i_load_use_hazard,
  output logic             o_step,
  output logic             o_write_pc,
  output logic             o_write_IF_ID,
  output logic             o_kill_IF_ID,
  output logic             o_bubble_ID_EX,
  output logic             o_done,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drainCnt_q, drainCnt_d;
  logic [CNT_W-1:0] cycleCount_q, cycleCount_d;
  logic             cmdAccept;
  logic             hz;

  assign o_cmd_ready    = (state_q == IDLE) || (state_q == RUN) || (state_q == DONE);
  assign o_step         = (state_q == RUN) || (state_q == STEP) || (state_q == DRAIN);
  // Stalls only matter while new instructions still enter; draining only pushes bubbles.
  assign hz             = i_load_use_hazard && o_step && (state_q != DRAIN);
  assign o_write_pc     = o_step && !hz && (state_q != DRAIN);
  assign o_write_IF_ID  = o_step && !hz;
  assign o_kill_IF_ID   = (state_q == DRAIN);
  assign o_bubble_ID_EX = hz;
  assign o_done         = (state_q == DONE);
  assign o_state        = state_q;
  assign o_cycle_count  = cycleCount_q;

  assign cmdAccept = i_cmd_valid && o_cmd_ready;

  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmdAccept && (i_cmd == CMD_RUN)) begin
          state_d = RUN;
        end else if (cmdAccept && (i_cmd == CMD_STEP)) begin
          state_d = STEP;
        end
      end
      RUN: begin
        // HALT wins over a simultaneous STOP; that STOP is consumed and dropped.
        if (i_halt_in_ID) begin
          state_d    = DRAIN;
          drainCnt_d = DRAIN_LOAD;
        end else if (cmdAccept && (i_cmd == CMD_STOP)) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        if (i_halt_in_ID) begin
          state_d    = DRAIN;
          drainCnt_d = DRAIN_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (drainCnt_q == '0) begin
          state_d = DONE;
        end else begin
          drainCnt_d = drainCnt_q - DW'(1);
        end
      end
      DONE: begin
        if (cmdAccept && (i_cmd == CMD_STOP)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cycleCount_d = cycleCount_q;
    if (o_step && (cycleCount_q != '1)) begin
      cycleCount_d = cycleCount_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      drainCnt_q   <= '0;
      cycleCount_q <= '0;
    end else begin
      state_q      <= state_d;
      drainCnt_q   <= drainCnt_d;
      cycleCount_q <= cycleCount_d;
    end
  end

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Scoreboard bench for pipeline_exec_ctrl: directed scenarios plus random commands,
// checked against a cycle-level reference model of the sequencer rules.
module tb_pipeline_exec_ctrl;

   localparam int DRAIN = 4;
   localparam longint SAT_MAX = 15;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmdValid = 1'b0;
   logic [1:0]  cmd = 2'b00;
   logic        haltInId = 1'b0;
   logic        loadUse = 1'b0;

   logic        cmdReady, stepO, writePc, writeIfId, killIfId, bubbleIdEx, doneO;
   logic [2:0]  stateO;
   logic [31:0] cycleCount;

   logic        cmdReadyS, stepS, writePcS, writeIfIdS, killIfIdS, bubbleIdExS, doneS;
   logic [2:0]  stateS;
   logic [3:0]  cycleCountS;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit     ready;
      bit     step;
      bit     wpc;
      bit     wifid;
      bit     kill;
      bit     bubble;
      bit     done;
      int     state;
      longint cnt;
      longint cntSat;
   } exp_t;

   exp_t expQ[$];

   // Reference model: a phase number, cycles of drain left, and total advance cycles
   int     mPhase;
   int     drainLeft;
   longint stepsSoFar;

   // Full-width instance for normal counting
   pipeline_exec_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
      .clk(clock), .rst(reset),
      .i_cmd_valid(cmdValid), .i_cmd(cmd), .o_cmd_ready(cmdReady),
      .i_halt_in_ID(haltInId), .i_load_use_hazard(loadUse),
      .o_step(stepO), .o_write_pc(writePc), .o_write_IF_ID(writeIfId),
      .o_kill_IF_ID(killIfId), .o_bubble_ID_EX(bubbleIdEx), .o_done(doneO),
      .o_state(stateO), .o_cycle_count(cycleCount)
   );

   // Narrow-counter instance on the same stimulus to exercise saturation
   pipeline_exec_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dutSat (
      .clk(clock), .rst(reset),
      .i_cmd_valid(cmdValid), .i_cmd(cmd), .o_cmd_ready(cmdReadyS),
      .i_halt_in_ID(haltInId), .i_load_use_hazard(loadUse),
      .o_step(stepS), .o_write_pc(writePcS), .o_write_IF_ID(writeIfIdS),
      .o_kill_IF_ID(killIfIdS), .o_bubble_ID_EX(bubbleIdExS), .o_done(doneS),
      .o_state(stateS), .o_cycle_count(cycleCountS)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic modelReset();
      mPhase     = 0;
      drainLeft  = 0;
      stepsSoFar = 0;
   endtask

   // One clock cycle of stimulus: drive inputs, push the expected outputs for this
   // cycle, then move the model across the coming rising edge.
   task automatic applyStimulus(input logic v, input logic [1:0] c, input logic h,
                                input logic z, input bit holdRst, input bit midRst);
      exp_t e;
      bit   stepNow;
      bit   stallNow;
      bit   accept;
      @(posedge clock);
      #1;
      cmdValid = v;
      cmd      = c;
      haltInId = h;
      loadUse  = z;
      reset    = holdRst;
      if (holdRst) modelReset();
      if (midRst) begin
         #2;
         reset = 1'b1;
         modelReset();
      end
      stepNow  = (mPhase >= 1) && (mPhase <= 3);
      stallNow = z && stepNow && (mPhase != 3);
      e.ready  = (mPhase == 0) || (mPhase == 1) || (mPhase == 4);
      e.step   = stepNow;
      e.wpc    = stepNow && !stallNow && (mPhase != 3);
      e.wifid  = stepNow && !stallNow;
      e.kill   = (mPhase == 3);
      e.bubble = stallNow;
      e.done   = (mPhase == 4);
      e.state  = mPhase;
      e.cnt    = stepsSoFar;
      e.cntSat = (stepsSoFar > SAT_MAX) ? SAT_MAX : stepsSoFar;
      expQ.push_back(e);
      if (holdRst || midRst) return;
      accept = v && e.ready;
      if (stepNow) stepsSoFar++;
      case (mPhase)
         0: begin
            if (accept && c == 2'b01) mPhase = 1;
            else if (accept && c == 2'b10) mPhase = 2;
         end
         1: begin
            if (h) begin
               mPhase = 3;
               drainLeft = DRAIN;
            end else if (accept && c == 2'b11) mPhase = 0;
         end
         2: begin
            if (h) begin
               mPhase = 3;
               drainLeft = DRAIN;
            end else mPhase = 0;
         end
         3: begin
            drainLeft--;
            if (drainLeft == 0) mPhase = 4;
         end
         4: begin
            if (accept && c == 2'b11) mPhase = 0;
         end
         default: mPhase = 0;
      endcase
   endtask

   task automatic cyc(input logic v, input logic [1:0] c, input logic h, input logic z);
      applyStimulus(v, c, h, z, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
   endtask

   // Monitor: every cycle the DUTs present outputs, compare against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("cmd_ready", longint'(cmdReady), longint'(e.ready));
            checkOutput("step", longint'(stepO), longint'(e.step));
            checkOutput("write_pc", longint'(writePc), longint'(e.wpc));
            checkOutput("write_IF_ID", longint'(writeIfId), longint'(e.wifid));
            checkOutput("kill_IF_ID", longint'(killIfId), longint'(e.kill));
            checkOutput("bubble_ID_EX", longint'(bubbleIdEx), longint'(e.bubble));
            checkOutput("done", longint'(doneO), longint'(e.done));
            checkOutput("state", longint'(stateO), longint'(e.state));
            checkOutput("cycle_count", longint'(cycleCount), e.cnt);
            checkOutput("sat_state", longint'(stateS), longint'(e.state));
            checkOutput("sat_step", longint'(stepS), longint'(e.step));
            checkOutput("sat_write_pc", longint'(writePcS), longint'(e.wpc));
            checkOutput("sat_cycle_count", longint'(cycleCountS), e.cntSat);
         end
      end
   end

   // Stimulus: directed scenarios first, then a random command stream
   initial begin
      modelReset();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

      // RUN, HALT after several cycles, drain to DONE, then STOP back to IDLE
      cyc(1'b1, 2'b01, 1'b0, 1'b0);
      idle(7);
      cyc(1'b0, 2'b00, 1'b1, 1'b0);
      idle(6);
      cyc(1'b1, 2'b01, 1'b0, 1'b0);
      cyc(1'b1, 2'b11, 1'b0, 1'b0);
      idle(2);

      // Three single steps spaced apart; commands offered during STEP are refused
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 2'b10, 1'b0, 1'b0);
         cyc(1'b1, 2'b01, 1'b0, 1'b0);
         idle(1);
      end

      // Load-use stall while running, then a hazard during DRAIN
      cyc(1'b1, 2'b01, 1'b0, 1'b0);
      cyc(1'b0, 2'b00, 1'b0, 1'b1);
      idle(1);
      cyc(1'b0, 2'b00, 1'b1, 1'b1);
      cyc(1'b0, 2'b00, 1'b0, 1'b1);
      cyc(1'b0, 2'b00, 1'b1, 1'b1);
      idle(4);
      cyc(1'b1, 2'b11, 1'b0, 1'b0);

      // STOP together with HALT while running: HALT wins
      cyc(1'b1, 2'b01, 1'b0, 1'b0);
      idle(1);
      cyc(1'b1, 2'b11, 1'b1, 1'b0);
      idle(5);
      cyc(1'b1, 2'b11, 1'b0, 1'b0);
      idle(1);

      // STEP that meets a HALT goes straight into DRAIN
      cyc(1'b1, 2'b10, 1'b0, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 1'b0);
      idle(5);
      cyc(1'b1, 2'b11, 1'b0, 1'b0);

      // Asynchronous reset in the middle of the second DRAIN cycle, then restart
      cyc(1'b1, 2'b01, 1'b0, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 1'b0);
      idle(1);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 2'b01, 1'b0, 1'b0);
      idle(22);
      cyc(1'b1, 2'b11, 1'b0, 1'b0);

      // Random traffic with occasional HALTs, stalls and asynchronous resets
      for (int i = 0; i < 800; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 3) == 0),
                       1'b0, ($urandom_range(0, 199) == 0));
      end

      @(posedge clock);
      @(negedge clock);
      #1;
      checkOutput("queue_drained", longint'(expQ.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
